led_step_ctrl: RTL and testbench

Upstream control stage for the 8-LED running-light chaser. Takes two raw push-buttons (speed, pause) and produces the single-cycle step_en pulse that drives the chaser's enable input. Internals: a selectable-rate prescaler, per-button synchronise/debounce/edge-detect, a 4-level speed register and a run/pause flag.

---
 rtl/led_step_ctrl.sv | 164 ++++++++++++++++
 tb/tb_led_step_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_step_ctrl.sv
// led_step_ctrl: button front-end and step-rate generator for the 8-LED chaser.
// Two raw buttons are synchronised, debounced and edge-detected; the speed
// press cycles a 4-level rate, the pause press toggles run/pause, and a
// prescaler emits a single-cycle step_en pulse once per selected period.

// Per-button synchroniser, debouncer and registered press detector.
module led_step_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_nxt;
  logic          press_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Two-flop synchroniser for the asynchronous raw button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
  always_comb begin
    cnt_nxt   = '0;
    level_nxt = level;
    press_nxt = 1'b0;
    if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        level_nxt = sync2;
        press_nxt = sync2;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Debounce state and registered rising-edge press event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      level <= level_nxt;
      press <= press_nxt;
    end
  end

endmodule

// Top level: speed/run control and step prescaler.
module led_step_ctrl #(
  parameter int unsigned BASE_DIV        = 6250000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_speed,
  input  logic       btn_pause,
  output logic       step_en,
  output logic [1:0] speed,
  output logic       running
);

  // Prescaler is sized for the slowest period (8 * BASE_DIV).
  localparam int unsigned PW = $clog2(8 * BASE_DIV);
  localparam logic [PW-1:0] LAST_S0 = PW'(8 * BASE_DIV - 1);
  localparam logic [PW-1:0] LAST_S1 = PW'(4 * BASE_DIV - 1);
  localparam logic [PW-1:0] LAST_S2 = PW'(2 * BASE_DIV - 1);
  localparam logic [PW-1:0] LAST_S3 = PW'(BASE_DIV - 1);

  logic          press_speed;
  logic          press_pause;
  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_nxt;
  logic [PW-1:0] cnt_last;
  logic [1:0]    speed_nxt;
  logic          running_nxt;
  logic          step_nxt;

  led_step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_speed (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_speed),
    .press(press_speed)
  );

  led_step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_pause (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_pause),
    .press(press_pause)
  );

  // Terminal prescaler count for the current speed (period - 1).
  always_comb begin
    cnt_last = LAST_S0;
    case (speed)
      2'd0:    cnt_last = LAST_S0;
      2'd1:    cnt_last = LAST_S1;
      2'd2:    cnt_last = LAST_S2;
      default: cnt_last = LAST_S3;
    endcase
  end

  // Presses take priority and restart the period; otherwise count while running.
  always_comb begin
    speed_nxt   = speed;
    running_nxt = running;
    cnt_nxt     = '0;
    step_nxt    = 1'b0;
    if (press_speed || press_pause) begin
      if (press_speed) begin
        speed_nxt = speed + 2'd1;
      end
      if (press_pause) begin
        running_nxt = ~running;
      end
    end else if (running) begin
      if (cnt == cnt_last) begin
        step_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + PW'(1);
      end
    end
  end

  // Control and prescaler registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      speed   <= 2'd0;
      running <= 1'b1;
      step_en <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      speed   <= speed_nxt;
      running <= running_nxt;
      step_en <= step_nxt;
    end
  end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Self-checking bench for led_step_ctrl with a window-based reference model.
module tb_led_step_ctrl;

  localparam int unsigned BASE_DIV = 4;
  localparam int unsigned DEB      = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_speed = 1'b0;
  logic       btn_pause = 1'b0;
  logic       step_en;
  logic [1:0] speed;
  logic       running;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_speed;
  bit m_run;
  bit m_step;
  int m_elapsed;
  bit m_pend_s, m_pend_p;
  bit m_deb_s, m_deb_p;
  bit hs[DEB+2];
  bit hp[DEB+2];

  always #5 clk = ~clk;

  led_step_ctrl #(
    .BASE_DIV(BASE_DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_speed(btn_speed),
    .btn_pause(btn_pause),
    .step_en  (step_en),
    .speed    (speed),
    .running  (running)
  );

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int period_of(input int s);
    return BASE_DIV * (8 >> s);
  endfunction

  task automatic model_reset();
    m_speed = 0; m_run = 1; m_step = 0; m_elapsed = 0;
    m_pend_s = 0; m_pend_p = 0; m_deb_s = 0; m_deb_p = 0;
    for (int i = 0; i < DEB + 2; i++) begin hs[i] = 0; hp[i] = 0; end
  endtask

  // One clock edge of the model: presses seen last edge apply now; a button
  // level is accepted once the last DEB synchronised samples all disagree.
  task automatic model_edge(input bit bs, input bit bp);
    bit all_s, all_p;
    if (m_pend_s || m_pend_p) begin
      if (m_pend_s) m_speed = (m_speed + 1) % 4;
      if (m_pend_p) m_run = !m_run;
      m_elapsed = 0; m_step = 0;
    end else if (m_run) begin
      m_elapsed++;
      if (m_elapsed == period_of(m_speed)) begin m_step = 1; m_elapsed = 0; end
      else m_step = 0;
    end else begin
      m_elapsed = 0; m_step = 0;
    end
    m_pend_s = 0; m_pend_p = 0;
    for (int i = 0; i < DEB + 1; i++) begin hs[i] = hs[i+1]; hp[i] = hp[i+1]; end
    hs[DEB+1] = bs; hp[DEB+1] = bp;
    all_s = 1; all_p = 1;
    for (int i = 0; i < DEB; i++) begin
      if (hs[i] == m_deb_s) all_s = 0;
      if (hp[i] == m_deb_p) all_p = 0;
    end
    if (all_s) begin m_deb_s = !m_deb_s; m_pend_s = m_deb_s; end
    if (all_p) begin m_deb_p = !m_deb_p; m_pend_p = m_deb_p; end
  endtask

  // Drive buttons for one cycle, advance the model at the edge, return at negedge.
  task automatic tick(input bit bs, input bit bp);
    btn_speed = bs; btn_pause = bp;
    @(posedge clk);
    model_edge(bs, bp);
    @(negedge clk);
  endtask

  task automatic hold(input bit bs, input bit bp, input int n);
    repeat (n) tick(bs, bp);
  endtask

  task automatic apply_reset();
    btn_speed = 0; btn_pause = 0;
    reset = 0;
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1;
  endtask

  task automatic test_reset();
    btn_speed = 0; btn_pause = 0; reset = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (step_en !== 1'b0) begin n_fail++; $display("FAIL reset_step_en: got %b want 0", step_en); end
    n_checks++; if (speed !== 2'd0) begin n_fail++; $display("FAIL reset_speed: got %0d want 0", speed); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL reset_running: got %b want 1", running); end
    model_reset();
    reset = 1;
  endtask

  task automatic test_first_pulse();
    int first, second;
    first = -1; second = -1;
    for (int t = 1; t <= 70; t++) begin
      tick(0, 0);
      n_checks++;
      if ({step_en, speed, running} !== {m_step, 2'(m_speed), m_run}) begin
        n_fail++; $display("FAIL first_pulse_model t=%0d: got %b%0d%b want %b%0d%b", t, step_en, speed, running, m_step, m_speed, m_run);
      end
      if (step_en === 1'b1) begin
        if (first < 0) first = t; else if (second < 0) second = t;
      end
    end
    n_checks++; if (first != 32) begin n_fail++; $display("FAIL first_pulse_time: got %0d want 32", first); end
    n_checks++; if (second != 64) begin n_fail++; $display("FAIL second_pulse_time: got %0d want 64", second); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 60; i++) begin
      tick(((i / 3) % 2) == 0, 0);
      n_checks++;
      if ({step_en, speed, running} !== {m_step, 2'(m_speed), m_run}) begin
        n_fail++; $display("FAIL bounce_model i=%0d: got %b%0d%b want %b%0d%b", i, step_en, speed, running, m_step, m_speed, m_run);
      end
    end
    for (int j = 1; j <= 20; j++) begin
      tick(1, 0);
      n_checks++;
      if ({step_en, speed, running} !== {m_step, 2'(m_speed), m_run}) begin
        n_fail++; $display("FAIL bounce_hold_model j=%0d: got %b%0d%b want %b%0d%b", j, step_en, speed, running, m_step, m_speed, m_run);
      end
      if (j == 10) begin
        n_checks++; if (speed !== 2'd0) begin n_fail++; $display("FAIL bounce_early: got %0d want 0", speed); end
      end
      if (j == 11) begin
        n_checks++; if (speed !== 2'd1) begin n_fail++; $display("FAIL bounce_latency: got %0d want 1", speed); end
      end
    end
    for (int j = 0; j < 50; j++) begin
      tick((j >= 20 && j < 25), 0);
      n_checks++;
      if ({step_en, speed, running} !== {m_step, 2'(m_speed), m_run}) begin
        n_fail++; $display("FAIL glitch_model j=%0d: got %b%0d%b want %b%0d%b", j, step_en, speed, running, m_step, m_speed, m_run);
      end
    end
    n_checks++; if (speed !== 2'd1) begin n_fail++; $display("FAIL glitch_ignored: got %0d want 1", speed); end
  endtask

  task automatic test_speed_cycle();
    int exp_gap[4] = '{16, 8, 4, 32};
    logic [1:0] exp_spd[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    int p1, p2;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 20; t++) begin
        tick(1, 0);
        n_checks++;
        if ({step_en, speed, running} !== {m_step, 2'(m_speed), m_run}) begin
          n_fail++; $display("FAIL speed_press_model k=%0d t=%0d: got %b%0d%b want %b%0d%b", k, t, step_en, speed, running, m_step, m_speed, m_run);
        end
      end
      n_checks++; if (speed !== exp_spd[k]) begin n_fail++; $display("FAIL speed_value k=%0d: got %0d want %0d", k, speed, exp_spd[k]); end
      p1 = -1; p2 = -1;
      for (int t = 1; t <= 300; t++) begin
        tick(0, 0);
        n_checks++;
        if ({step_en, speed, running} !== {m_step, 2'(m_speed), m_run}) begin
          n_fail++; $display("FAIL speed_low_model k=%0d t=%0d: got %b%0d%b want %b%0d%b", k, t, step_en, speed, running, m_step, m_speed, m_run);
        end
        if (step_en === 1'b1) begin
          if (p1 < 0) p1 = t; else if (p2 < 0) p2 = t;
        end
        if (t >= 20 && p2 >= 0) break;
      end
      n_checks++; if (p2 < 0 || (p2 - p1) != exp_gap[k]) begin n_fail++; $display("FAIL speed_gap k=%0d: got %0d want %0d", k, p2 - p1, exp_gap[k]); end
    end
  endtask

  task automatic test_pause();
    int rise_t, first_t, pulses;
    pulses = 0;
    hold(0, 1, 20);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b want 0", running); end
    for (int t = 0; t < 300; t++) begin
      tick(0, 0);
      if (step_en === 1'b1) pulses++;
      n_checks++;
      if ({step_en, speed, running} !== {m_step, 2'(m_speed), m_run}) begin
        n_fail++; $display("FAIL pause_model t=%0d: got %b%0d%b want %b%0d%b", t, step_en, speed, running, m_step, m_speed, m_run);
      end
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL pause_no_step: got %0d pulses want 0", pulses); end
    rise_t = -1; first_t = -1;
    for (int t = 1; t <= 120; t++) begin
      tick(0, t <= 20);
      if (running === 1'b1 && rise_t < 0) rise_t = t;
      if (step_en === 1'b1 && first_t < 0) first_t = t;
    end
    n_checks++; if (rise_t != 11) begin n_fail++; $display("FAIL resume_latency: got %0d want 11", rise_t); end
    n_checks++; if (first_t < 0 || (first_t - rise_t) != 32) begin n_fail++; $display("FAIL resume_first_pulse: got %0d want 32", first_t - rise_t); end
  endtask

  task automatic test_coincide();
    int p, first_t, early;
    hold(1, 0, 20); hold(0, 0, 20);
    hold(1, 0, 20); hold(0, 0, 20);
    n_checks++; if (speed !== 2'd2) begin n_fail++; $display("FAIL coincide_setup: got %0d want 2", speed); end
    early = 0;
    for (int t = 1; t <= 40; t++) begin
      tick(t <= 20, t <= 20);
      if (t >= 11 && step_en === 1'b1) early++;
      n_checks++;
      if ({step_en, speed, running} !== {m_step, 2'(m_speed), m_run}) begin
        n_fail++; $display("FAIL both_model t=%0d: got %b%0d%b want %b%0d%b", t, step_en, speed, running, m_step, m_speed, m_run);
      end
    end
    n_checks++; if ({speed, running} !== {2'd3, 1'b0}) begin n_fail++; $display("FAIL both_press: got %0d/%b want 3/0", speed, running); end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL both_no_step: got %0d pulses want 0", early); end
    hold(0, 1, 20); hold(0, 0, 20);
    hold(1, 0, 20); hold(0, 0, 20);
    n_checks++; if ({speed, running} !== {2'd0, 1'b1}) begin n_fail++; $display("FAIL coincide_prep: got %0d/%b want 0/1", speed, running); end
    p = 0;
    while (step_en !== 1'b1 && p < 100) begin tick(0, 0); p++; end
    n_checks++; if (step_en !== 1'b1) begin n_fail++; $display("FAIL coincide_wait: no step_en within %0d cycles", p); end
    early = 0; first_t = -1;
    for (int t = 1; t <= 60; t++) begin
      tick(t >= 22 && t <= 41, 0);
      if (step_en === 1'b1) begin
        if (t < 48) early++;
        else if (first_t < 0) first_t = t;
      end
      if (t == 32) begin
        n_checks++; if (speed !== 2'd1) begin n_fail++; $display("FAIL coincide_speed: got %0d want 1", speed); end
      end
      n_checks++;
      if ({step_en, speed, running} !== {m_step, 2'(m_speed), m_run}) begin
        n_fail++; $display("FAIL coincide_model t=%0d: got %b%0d%b want %b%0d%b", t, step_en, speed, running, m_step, m_speed, m_run);
      end
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL coincide_no_pulse: got %0d pulses want 0", early); end
    n_checks++; if (first_t != 48) begin n_fail++; $display("FAIL coincide_next_pulse: got %0d want 48", first_t); end
  endtask

  task automatic test_reset_mid();
    hold(1, 0, 20); hold(0, 0, 20);
    hold(1, 0, 20); hold(0, 0, 20);
    hold(0, 1, 20); hold(0, 0, 20);
    n_checks++; if ({speed, running} !== {2'd3, 1'b0}) begin n_fail++; $display("FAIL mid_setup: got %0d/%b want 3/0", speed, running); end
    hold(1, 0, 3);
    @(posedge clk);
    #2 reset = 0;
    #1;
    n_checks++; if ({step_en, speed, running} !== {1'b0, 2'd0, 1'b1}) begin n_fail++; $display("FAIL mid_reset_async: got %b%0d%b want 001", step_en, speed, running); end
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1;
    for (int t = 1; t <= 14; t++) begin
      tick(1, 0);
      if (t == 10) begin
        n_checks++; if (speed !== 2'd0) begin n_fail++; $display("FAIL mid_early: got %0d want 0", speed); end
      end
      if (t == 11) begin
        n_checks++; if (speed !== 2'd1) begin n_fail++; $display("FAIL mid_held_press: got %0d want 1", speed); end
      end
      n_checks++;
      if ({step_en, speed, running} !== {m_step, 2'(m_speed), m_run}) begin
        n_fail++; $display("FAIL mid_model t=%0d: got %b%0d%b want %b%0d%b", t, step_en, speed, running, m_step, m_speed, m_run);
      end
    end
    hold(0, 0, 20);
  endtask

  task automatic test_random();
    int len_s, len_p;
    bit lvl_s, lvl_p;
    logic prev;
    len_s = 0; len_p = 0; lvl_s = 0; lvl_p = 0; prev = step_en;
    for (int t = 0; t < 2500; t++) begin
      if (len_s == 0) begin lvl_s = 1'($urandom_range(0, 1)); len_s = $urandom_range(1, 24); end
      if (len_p == 0) begin lvl_p = 1'($urandom_range(0, 1)); len_p = $urandom_range(1, 30); end
      len_s--; len_p--;
      tick(lvl_s, lvl_p);
      n_checks++;
      if ({step_en, speed, running} !== {m_step, 2'(m_speed), m_run}) begin
        n_fail++; $display("FAIL random_model t=%0d: got %b%0d%b want %b%0d%b", t, step_en, speed, running, m_step, m_speed, m_run);
      end
      n_checks++;
      if (prev === 1'b1 && step_en === 1'b1) begin n_fail++; $display("FAIL random_double_step t=%0d: got 11 want not 11", t); end
      prev = step_en;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_pulse();
    test_bounce();
    test_speed_cycle();
    test_pause();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
